// File: rtl/clk_period_meter.sv
// Measures high/low phase lengths of a slow, i_clk-synchronous square wave and
// checks each completed period against expected lengths with stuck detection.
module clk_period_meter #(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned EXPECT_HIGH = 5,
    parameter int unsigned EXPECT_LOW  = 5,
    parameter int unsigned TOL         = 0,
    parameter int unsigned TIMEOUT     = 1024
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_sig,
    output logic [CNT_W-1:0] o_high_cnt,
    output logic [CNT_W-1:0] o_low_cnt,
    output logic [CNT_W:0]   o_period,
    output logic             o_valid,
    output logic             o_err,
    output logic             o_err_sticky,
    output logic             o_stuck
);

    localparam int unsigned      DEV_W       = CNT_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TIMEOUT = CNT_W'(TIMEOUT);
    localparam logic [DEV_W-1:0] EXP_HIGH_V  = DEV_W'(EXPECT_HIGH);
    localparam logic [DEV_W-1:0] EXP_LOW_V   = DEV_W'(EXPECT_LOW);
    localparam logic [DEV_W-1:0] TOL_V       = DEV_W'(TOL);

    typedef enum logic [1:0] {
        S_SYNC = 2'd0,
        S_HIGH = 2'd1,
        S_LOW  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_prev;
    logic             r_armed;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_inc;

    logic [CNT_W-1:0] r_high_cnt;
    logic [CNT_W-1:0] r_low_cnt;
    logic [CNT_W:0]   r_period;
    logic             r_valid;
    logic             r_err;
    logic             r_err_sticky;
    logic             r_stuck;

    logic [CNT_W-1:0] w_high_nxt;
    logic [CNT_W-1:0] w_low_nxt;
    logic [CNT_W:0]   w_period_nxt;
    logic             w_valid_nxt;
    logic             w_err_nxt;
    logic             w_err_sticky_nxt;
    logic             w_stuck_nxt;

    logic             w_rise;
    logic             w_fall;
    logic             w_err_term;

    // Absolute deviation of a measured length from its expectation, signed math.
    function automatic logic [DEV_W-1:0] abs_dev(input logic [CNT_W-1:0] meas,
                                                 input logic [DEV_W-1:0] expv);
        logic [DEV_W-1:0] d;
        d = {1'b0, meas} - expv;
        return d[DEV_W-1] ? (DEV_W'(0) - d) : d;
    endfunction

    // The first sample after reset only primes r_prev, so a signal that is
    // already high out of reset is not mistaken for a rising edge.
    assign w_rise = r_armed & i_sig & ~r_prev;
    assign w_fall = r_armed & ~i_sig & r_prev;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_SYNC;
            r_prev       <= 1'b0;
            r_armed      <= 1'b0;
            r_cnt        <= '0;
            r_high_cnt   <= '0;
            r_low_cnt    <= '0;
            r_period     <= '0;
            r_valid      <= 1'b0;
            r_err        <= 1'b0;
            r_err_sticky <= 1'b0;
            r_stuck      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_prev       <= i_sig;
            r_armed      <= 1'b1;
            r_cnt        <= w_cnt_nxt;
            r_high_cnt   <= w_high_nxt;
            r_low_cnt    <= w_low_nxt;
            r_period     <= w_period_nxt;
            r_valid      <= w_valid_nxt;
            r_err        <= w_err_nxt;
            r_err_sticky <= w_err_sticky_nxt;
            r_stuck      <= w_stuck_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_high_nxt       = r_high_cnt;
        w_low_nxt        = r_low_cnt;
        w_period_nxt     = r_period;
        w_valid_nxt      = 1'b0;
        w_err_nxt        = 1'b0;
        w_err_sticky_nxt = r_err_sticky;
        w_stuck_nxt      = r_stuck;
        w_cnt_inc        = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_ONE;
        w_err_term       = (abs_dev(r_high_cnt, EXP_HIGH_V) > TOL_V) ||
                           (abs_dev(r_cnt, EXP_LOW_V) > TOL_V);

        case (r_state)
            S_SYNC: begin
                if (w_rise) begin
                    w_cnt_nxt   = CNT_ONE;
                    w_stuck_nxt = 1'b0;
                    w_state_nxt = S_HIGH;
                end
            end
            S_HIGH: begin
                if (w_fall) begin
                    w_high_nxt  = r_cnt;
                    w_cnt_nxt   = CNT_ONE;
                    w_state_nxt = S_LOW;
                end else if (r_cnt == CNT_TIMEOUT) begin
                    w_stuck_nxt = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_SYNC;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            S_LOW: begin
                // Rising edge closes the period: report and check in one cycle.
                if (w_rise) begin
                    w_low_nxt        = r_cnt;
                    w_period_nxt     = {1'b0, r_high_cnt} + {1'b0, r_cnt};
                    w_valid_nxt      = 1'b1;
                    w_err_nxt        = w_err_term;
                    w_err_sticky_nxt = r_err_sticky | w_err_term;
                    w_cnt_nxt        = CNT_ONE;
                    w_state_nxt      = S_HIGH;
                end else if (r_cnt == CNT_TIMEOUT) begin
                    w_stuck_nxt = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_SYNC;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_SYNC;
            end
        endcase
    end

    assign o_high_cnt   = r_high_cnt;
    assign o_low_cnt    = r_low_cnt;
    assign o_period     = r_period;
    assign o_valid      = r_valid;
    assign o_err        = r_err;
    assign o_err_sticky = r_err_sticky;
    assign o_stuck      = r_stuck;

endmodule
